// File: rtl/a2mem_pkg.sv
// Shared definitions for the Apple II memory/video soft-switch controller:
// soft-switch addresses, the captured bus cycle type and switch bit indices.
package a2mem_pkg;

    // C000-C00F: write-only //e switches (even clears, odd sets)
    localparam logic [15:0] SW_STORE80_OFF   = 16'hC000, SW_STORE80_ON   = 16'hC001;
    localparam logic [15:0] SW_RAMRD_OFF     = 16'hC002, SW_RAMRD_ON     = 16'hC003;
    localparam logic [15:0] SW_RAMWRT_OFF    = 16'hC004, SW_RAMWRT_ON    = 16'hC005;
    localparam logic [15:0] SW_INTCXROM_OFF  = 16'hC006, SW_INTCXROM_ON  = 16'hC007;
    localparam logic [15:0] SW_ALTZP_OFF     = 16'hC008, SW_ALTZP_ON     = 16'hC009;
    localparam logic [15:0] SW_SLOTC3ROM_OFF = 16'hC00A, SW_SLOTC3ROM_ON = 16'hC00B;
    localparam logic [15:0] SW_80COL_OFF     = 16'hC00C, SW_80COL_ON     = 16'hC00D;
    localparam logic [15:0] SW_ALTCHAR_OFF   = 16'hC00E, SW_ALTCHAR_ON   = 16'hC00F;

    // C050-C05F: read/write video and annunciator switches
    localparam logic [15:0] SW_TEXT_OFF  = 16'hC050, SW_TEXT_ON  = 16'hC051;
    localparam logic [15:0] SW_MIXED_OFF = 16'hC052, SW_MIXED_ON = 16'hC053;
    localparam logic [15:0] SW_PAGE2_OFF = 16'hC054, SW_PAGE2_ON = 16'hC055;
    localparam logic [15:0] SW_HIRES_OFF = 16'hC056, SW_HIRES_ON = 16'hC057;
    localparam logic [15:0] SW_AN0_OFF   = 16'hC058, SW_AN0_ON   = 16'hC059;
    localparam logic [15:0] SW_AN1_OFF   = 16'hC05A, SW_AN1_ON   = 16'hC05B;
    localparam logic [15:0] SW_AN2_OFF   = 16'hC05C, SW_AN2_ON   = 16'hC05D;
    localparam logic [15:0] SW_AN3_OFF   = 16'hC05E, SW_AN3_ON   = 16'hC05F;

    // IIgs video registers
    localparam logic [15:0] IIGS_MONOCOLOR = 16'hC021;
    localparam logic [15:0] IIGS_TEXTCOLOR = 16'hC022;
    localparam logic [15:0] IIGS_NEWVIDEO  = 16'hC029;
    localparam logic [15:0] IIGS_BORDER    = 16'hC034;

    localparam logic [15:0] CFFF_INTC8_RESET = 16'hCFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw_n;
    } bus_cycle_t;

    // Bits 0-7 hold the C000 group, bits 8-15 the C050 group
    typedef enum logic [3:0] {
        IDX_STORE80   = 4'd0,
        IDX_RAMRD     = 4'd1,
        IDX_RAMWRT    = 4'd2,
        IDX_INTCXROM  = 4'd3,
        IDX_ALTZP     = 4'd4,
        IDX_SLOTC3ROM = 4'd5,
        IDX_COL80     = 4'd6,
        IDX_ALTCHAR   = 4'd7,
        IDX_TEXT      = 4'd8,
        IDX_MIXED     = 4'd9,
        IDX_PAGE2     = 4'd10,
        IDX_HIRES     = 4'd11,
        IDX_AN0       = 4'd12,
        IDX_AN1       = 4'd13,
        IDX_AN2       = 4'd14,
        IDX_AN3       = 4'd15
    } sw_idx_e;

    // addr[6] separates C00x from C05x; addr[3:1] picks the switch pair
    function automatic sw_idx_e sw_index(input logic bank, input logic [2:0] sel);
        return sw_idx_e'({bank, sel});
    endfunction

endpackage

// File: rtl/a2mem_if.sv
// Soft-switch state bus: one master (a2mem_switch_ctrl), any number of
// video / memory-mapping / slot consumers on the slave modport.
interface a2mem_if;
    logic       store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar;
    logic       text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3;
    logic       intc8rom;
    logic [2:0] slotrom;
    logic [3:0] text_color, background_color, border_color;
    logic       monochrome_mode, monochrome_dhires_mode, shrg_mode, linearize_mode;
    logic       aux_mem;
    logic [7:0] keycode;
    logic       keypress_strobe, key_armed;

    modport master (
        output store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar,
        output text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3,
        output intc8rom, slotrom, text_color, background_color, border_color,
        output monochrome_mode, monochrome_dhires_mode, shrg_mode, linearize_mode,
        output aux_mem, keycode, keypress_strobe, key_armed
    );

    modport slave (
        input store80, ramrd, ramwrt, intcxrom, altzp, slotc3rom, col80, altchar,
        input text_mode, mixed_mode, page2, hires_mode, an0, an1, an2, an3,
        input intc8rom, slotrom, text_color, background_color, border_color,
        input monochrome_mode, monochrome_dhires_mode, shrg_mode, linearize_mode,
        input aux_mem, keycode, keypress_strobe, key_armed
    );
endinterface

// File: rtl/a2mem_key_latch.sv
// Keyboard latch: captures the key code on an armed C00x read with bit 7 set,
// pulses keypress_strobe for one clock, and re-arms on the strobe-clear access.
module a2mem_key_latch (
    input  logic       clk_logic,
    input  logic       system_reset,
    input  logic       key_read,
    input  logic       key_rearm,
    input  logic [7:0] key_data,
    output logic [7:0] keycode,
    output logic       keypress_strobe,
    output logic       key_armed
);

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            keycode         <= '0;
            keypress_strobe <= 1'b0;
            key_armed       <= 1'b1;
        end else begin
            keypress_strobe <= 1'b0;
            if (key_read && key_armed) begin
                keycode         <= key_data;
                keypress_strobe <= 1'b1;
                key_armed       <= 1'b0;
            end
            if (key_rearm)
                key_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/a2mem_switch_ctrl.sv
// Snoops captured Apple II bus cycles and drives all soft-switch state on a2mem_if.
// Optional IIgs video registers are built when IIGS_SWITCHES_EN is defined.
module a2mem_switch_ctrl
    import a2mem_pkg::*;
#(
    parameter bit         ENABLE_AUX     = 1'b1,
    parameter logic [7:0] KEY_REARM_ADDR = 8'h10
) (
    input  logic        clk_logic,
    input  logic        system_reset,
    input  logic        bus_strobe,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_data,
    input  logic        bus_rw_n,
    input  logic        bus_enable,
    a2mem_if.master     a2mem
);

    bus_cycle_t  cyc;
    logic        cyc_valid;
    logic [15:0] sw_q, sw_next;
    logic        intc8_q, intc8_next;
    logic [2:0]  slot_q, slot_next;
    logic        aux_q, aux_next, aux_target;
    logic        in_c00x, in_c05x, in_slot, is_cfff, iigs_shadow;
    logic        key_read, key_rearm;

    // S0: capture
    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            cyc_valid <= 1'b0;
            cyc       <= '0;
        end else begin
            cyc_valid <= bus_strobe && bus_enable;
            if (bus_strobe && bus_enable)
                cyc <= '{addr: bus_addr, data: bus_data, rw_n: bus_rw_n};
        end
    end

    assign in_c00x   = cyc.addr[15:4] == 12'hC00;
    assign in_c05x   = cyc.addr[15:4] == 12'hC05;
    assign in_slot   = (cyc.addr[15:11] == 5'b11000) && (cyc.addr[10:8] != 3'd0);
    assign is_cfff   = cyc.addr == CFFF_INTC8_RESET;
    assign key_read  = cyc_valid && cyc.rw_n && in_c00x && cyc.data[7];
    assign key_rearm = cyc_valid && (cyc.addr == {8'hC0, KEY_REARM_ADDR});

    // Aux targeting is judged against the switches as they stood before this access
    always_comb begin
        aux_target = cyc.rw_n ? sw_q[IDX_RAMRD] : sw_q[IDX_RAMWRT];
        if (cyc.addr < 16'h0200 || cyc.addr >= 16'hD000)
            aux_target = sw_q[IDX_ALTZP];
        else if (cyc.addr >= 16'hC000)
            aux_target = 1'b0;
        else if (iigs_shadow)
            aux_target = 1'b1;
        else if (sw_q[IDX_STORE80] && cyc.addr[15:10] == 6'b000001)
            aux_target = sw_q[IDX_PAGE2];
        else if (sw_q[IDX_STORE80] && sw_q[IDX_HIRES] && cyc.addr[15:13] == 3'b001)
            aux_target = sw_q[IDX_PAGE2];
    end

    // S1: decode and update
    always_comb begin
        sw_next    = sw_q;
        intc8_next = intc8_q;
        slot_next  = slot_q;
        aux_next   = aux_q;
        if (cyc_valid) begin
            if (in_c00x && !cyc.rw_n && ENABLE_AUX)
                sw_next[sw_index(cyc.addr[6], cyc.addr[3:1])] = cyc.addr[0];
            if (in_c05x)
                sw_next[sw_index(cyc.addr[6], cyc.addr[3:1])] = cyc.addr[0];
            if (in_slot) begin
                slot_next = cyc.addr[10:8];
                if (cyc.addr[10:8] == 3'd3 && !sw_q[IDX_SLOTC3ROM] && ENABLE_AUX)
                    intc8_next = 1'b1;
            end
            if (is_cfff) begin
                intc8_next = 1'b0;
                slot_next  = 3'd0;
            end
            aux_next = ENABLE_AUX ? aux_target : 1'b0;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            sw_q    <= 16'h0100;
            intc8_q <= 1'b0;
            slot_q  <= 3'd0;
            aux_q   <= 1'b0;
        end else begin
            sw_q    <= sw_next;
            intc8_q <= intc8_next;
            slot_q  <= slot_next;
            aux_q   <= aux_next;
        end
    end

`ifdef IIGS_SWITCHES_EN
    logic [3:0] text_color_q, bg_color_q, border_color_q;
    logic       mono_q, mono_dhires_q, shrg_q, linearize_q;

    assign iigs_shadow = shrg_q && !cyc.rw_n && cyc.addr >= 16'h2000 && cyc.addr < 16'hA000;

    always_ff @(posedge clk_logic) begin
        if (system_reset) begin
            text_color_q   <= 4'hF;
            bg_color_q     <= 4'h6;
            border_color_q <= 4'h6;
            mono_q         <= 1'b0;
            mono_dhires_q  <= 1'b0;
            shrg_q         <= 1'b0;
            linearize_q    <= 1'b0;
        end else if (cyc_valid && !cyc.rw_n) begin
            if (cyc.addr == IIGS_TEXTCOLOR) begin
                text_color_q <= cyc.data[7:4];
                bg_color_q   <= cyc.data[3:0];
            end
            if (cyc.addr == IIGS_BORDER)
                border_color_q <= cyc.data[3:0];
            if (cyc.addr == IIGS_NEWVIDEO) begin
                shrg_q        <= cyc.data[7];
                linearize_q   <= cyc.data[6];
                mono_dhires_q <= cyc.data[5];
            end
            if (cyc.addr == IIGS_MONOCOLOR)
                mono_q <= cyc.data[7];
        end
    end

    assign a2mem.text_color             = text_color_q;
    assign a2mem.background_color       = bg_color_q;
    assign a2mem.border_color           = border_color_q;
    assign a2mem.monochrome_mode        = mono_q;
    assign a2mem.monochrome_dhires_mode = mono_dhires_q;
    assign a2mem.shrg_mode              = shrg_q;
    assign a2mem.linearize_mode         = linearize_q;
`else
    assign iigs_shadow                  = 1'b0;
    assign a2mem.text_color             = 4'hF;
    assign a2mem.background_color       = 4'h6;
    assign a2mem.border_color           = 4'h6;
    assign a2mem.monochrome_mode        = 1'b0;
    assign a2mem.monochrome_dhires_mode = 1'b0;
    assign a2mem.shrg_mode              = 1'b0;
    assign a2mem.linearize_mode         = 1'b0;
`endif

    a2mem_key_latch u_key_latch (
        .clk_logic       (clk_logic),
        .system_reset    (system_reset),
        .key_read        (key_read),
        .key_rearm       (key_rearm),
        .key_data        (cyc.data),
        .keycode         (a2mem.keycode),
        .keypress_strobe (a2mem.keypress_strobe),
        .key_armed       (a2mem.key_armed)
    );

    assign a2mem.store80    = sw_q[IDX_STORE80];
    assign a2mem.ramrd      = sw_q[IDX_RAMRD];
    assign a2mem.ramwrt     = sw_q[IDX_RAMWRT];
    assign a2mem.intcxrom   = sw_q[IDX_INTCXROM];
    assign a2mem.altzp      = sw_q[IDX_ALTZP];
    assign a2mem.slotc3rom  = sw_q[IDX_SLOTC3ROM];
    assign a2mem.col80      = sw_q[IDX_COL80];
    assign a2mem.altchar    = sw_q[IDX_ALTCHAR];
    assign a2mem.text_mode  = sw_q[IDX_TEXT];
    assign a2mem.mixed_mode = sw_q[IDX_MIXED];
    assign a2mem.page2      = sw_q[IDX_PAGE2];
    assign a2mem.hires_mode = sw_q[IDX_HIRES];
    assign a2mem.an0        = sw_q[IDX_AN0];
    assign a2mem.an1        = sw_q[IDX_AN1];
    assign a2mem.an2        = sw_q[IDX_AN2];
    assign a2mem.an3        = sw_q[IDX_AN3];
    assign a2mem.intc8rom   = intc8_q;
    assign a2mem.slotrom    = slot_q;
    assign a2mem.aux_mem    = aux_q;

endmodule

// File: tb/tb_a2mem_switch_ctrl.sv
// Self-checking bench for a2mem_switch_ctrl: directed scenarios plus randomized
// back-to-back traffic against a behavioural model. IIgs checks need IIGS_SWITCHES_EN.
module tb_a2mem_switch_ctrl;

    typedef logic [46:0] snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;
    logic        rw_n = 1'b1;
    logic        en = 1'b1;

    int checks = 0;
    int passed = 0;

    a2mem_if mem ();

    a2mem_switch_ctrl #(.ENABLE_AUX(1'b1), .KEY_REARM_ADDR(8'h10)) dut (
        .clk_logic    (clk),
        .system_reset (rst),
        .bus_strobe   (strobe),
        .bus_addr     (addr),
        .bus_data     (data),
        .bus_rw_n     (rw_n),
        .bus_enable   (en),
        .a2mem        (mem)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: switch groups as 8-bit images, bit i = switch pair i
    bit [7:0] m_c0, m_c5;
    bit       m_c8, m_aux, m_armed, m_kstb;
    bit [2:0] m_slot;
    bit [7:0] m_key;
    bit [3:0] m_tc, m_bg, m_bd;
    bit       m_mono, m_mdh, m_shrg, m_lin;

    localparam snap_t RST_SNAP = {8'h00, 8'h01, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0,
                                  4'hF, 4'h6, 4'h6, 4'b0000};

    task automatic model_reset();
        m_c0 = 8'h00; m_c5 = 8'h01; m_c8 = 0; m_slot = 0; m_aux = 0;
        m_key = 8'h00; m_armed = 1; m_kstb = 0;
        m_tc = 4'hF; m_bg = 4'h6; m_bd = 4'h6;
        m_mono = 0; m_mdh = 0; m_shrg = 0; m_lin = 0;
    endtask

    task automatic model_apply(input logic [15:0] a, input logic [7:0] d, input logic rd);
        int page = int'(a) / 256;
        bit store80 = m_c0[0], page2 = m_c5[2], hires = m_c5[3];
        if (a < 16'h0200 || a >= 16'hD000)            m_aux = m_c0[4];
        else if (page >= 'hC0)                          m_aux = 0;
`ifdef IIGS_SWITCHES_EN
        else if (m_shrg && !rd && a >= 16'h2000 && a <= 16'h9FFF) m_aux = 1;
`endif
        else if (store80 && page >= 4 && page <= 7)     m_aux = page2;
        else if (store80 && hires && page >= 'h20 && page <= 'h3F) m_aux = page2;
        else                                            m_aux = rd ? m_c0[1] : m_c0[2];

        m_kstb = 0;
        if (rd && a >= 16'hC000 && a <= 16'hC00F && d[7] && m_armed) begin
            m_key = d; m_kstb = 1; m_armed = 0;
        end
        if (a == 16'hC010) m_armed = 1;
        if (!rd && a >= 16'hC000 && a <= 16'hC00F) m_c0[(a - 16'hC000) / 2] = a[0];
        if (a >= 16'hC050 && a <= 16'hC05F)        m_c5[(a - 16'hC050) / 2] = a[0];
        if (page >= 'hC1 && page <= 'hC7) begin
            m_slot = 3'(page - 'hC0);
            if (m_slot == 3 && !m_c0[5]) m_c8 = 1;
        end
        if (a == 16'hCFFF) begin m_c8 = 0; m_slot = 0; end
`ifdef IIGS_SWITCHES_EN
        if (!rd) begin
            if (a == 16'hC022) begin m_tc = d[7:4]; m_bg = d[3:0]; end
            if (a == 16'hC034) m_bd = d[3:0];
            if (a == 16'hC029) begin m_shrg = d[7]; m_lin = d[6]; m_mdh = d[5]; end
            if (a == 16'hC021) m_mono = d[7];
        end
`endif
    endtask

    function automatic snap_t model_snap();
        return {m_c0, m_c5, m_c8, m_slot, m_aux, m_key, m_armed, m_kstb,
                m_tc, m_bg, m_bd, m_mono, m_mdh, m_shrg, m_lin};
    endfunction

    function automatic snap_t dut_snap();
        return {mem.altchar, mem.col80, mem.slotc3rom, mem.altzp, mem.intcxrom,
                mem.ramwrt, mem.ramrd, mem.store80,
                mem.an3, mem.an2, mem.an1, mem.an0, mem.hires_mode, mem.page2,
                mem.mixed_mode, mem.text_mode,
                mem.intc8rom, mem.slotrom, mem.aux_mem, mem.keycode, mem.key_armed,
                mem.keypress_strobe, mem.text_color, mem.background_color,
                mem.border_color, mem.monochrome_mode, mem.monochrome_dhires_mode,
                mem.shrg_mode, mem.linearize_mode};
    endfunction

    // One strobe; returns at the first negedge where its result is visible
    task automatic access(input logic [15:0] a, input logic [7:0] d, input logic rd);
        @(negedge clk);
        addr = a; data = d; rw_n = rd; strobe = 1'b1;
        model_apply(a, d, rd);
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if (dut_snap() !== RST_SNAP)
            $display("FAIL reset_state got %h expected %h", dut_snap(), RST_SNAP);
        else passed++;
    endtask

    task automatic test_switch_write();
        access(16'hC001, 8'h00, 1'b0);
        access(16'hC055, 8'h00, 1'b0);
        access(16'hC057, 8'h00, 1'b1);
        checks++;
        if ({mem.store80, mem.page2, mem.hires_mode, mem.text_mode} !== 4'b1111)
            $display("FAIL switch_write store80/page2/hires/text got %b expected 1111",
                     {mem.store80, mem.page2, mem.hires_mode, mem.text_mode});
        else passed++;
    endtask

    task automatic test_read_only();
        access(16'hC000, 8'h00, 1'b0);
        access(16'hC001, 8'h00, 1'b1);
        checks++;
        if (mem.store80 !== 1'b0)
            $display("FAIL read_c001 store80 got %b expected 0", mem.store80);
        else passed++;
        access(16'hC001, 8'h00, 1'b0);
        access(16'hC050, 8'h00, 1'b0);
        checks++;
        if ({mem.store80, mem.text_mode} !== 2'b10)
            $display("FAIL write_c050 store80/text got %b expected 10",
                     {mem.store80, mem.text_mode});
        else passed++;
    endtask

    task automatic test_bus_enable();
        en = 1'b0;
        @(negedge clk);
        addr = 16'hC00F; data = 8'h00; rw_n = 1'b0; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        checks++;
        if (mem.altchar !== 1'b0)
            $display("FAIL bus_enable_ignore altchar got %b expected 0", mem.altchar);
        else passed++;
    endtask

    task automatic test_aux_mem();
        access(16'h0400, 8'h12, 1'b0);
        checks++;
        if (mem.aux_mem !== 1'b1) $display("FAIL aux_0400 got %b expected 1", mem.aux_mem);
        else passed++;
        access(16'h0800, 8'h34, 1'b0);
        checks++;
        if (mem.aux_mem !== 1'b0) $display("FAIL aux_0800_wr got %b expected 0", mem.aux_mem);
        else passed++;
        access(16'hC003, 8'h00, 1'b0);
        access(16'h0800, 8'h00, 1'b1);
        checks++;
        if (mem.aux_mem !== 1'b1) $display("FAIL aux_0800_rd got %b expected 1", mem.aux_mem);
        else passed++;
    endtask

    task automatic test_slot_rom();
        access(16'hC300, 8'h00, 1'b1);
        checks++;
        if ({mem.intc8rom, mem.slotrom} !== 4'b1_011)
            $display("FAIL slot_c300 intc8rom/slotrom got %b expected 1011",
                     {mem.intc8rom, mem.slotrom});
        else passed++;
        access(16'hCFFF, 8'h00, 1'b1);
        checks++;
        if ({mem.intc8rom, mem.slotrom} !== 4'b0_000)
            $display("FAIL slot_cfff intc8rom/slotrom got %b expected 0000",
                     {mem.intc8rom, mem.slotrom});
        else passed++;
        access(16'hC00B, 8'h00, 1'b0);
        access(16'hC300, 8'h00, 1'b1);
        checks++;
        if ({mem.intc8rom, mem.slotrom} !== 4'b0_011)
            $display("FAIL slot_c300_slotc3 intc8rom/slotrom got %b expected 0011",
                     {mem.intc8rom, mem.slotrom});
        else passed++;
        access(16'hC00A, 8'h00, 1'b0);
    endtask

    task automatic test_keyboard();
        access(16'hC000, 8'hC1, 1'b1);
        checks++;
        if ({mem.keypress_strobe, mem.keycode, mem.key_armed} !== {1'b1, 8'hC1, 1'b0})
            $display("FAIL key_first strobe/code/armed got %b/%h/%b expected 1/c1/0",
                     mem.keypress_strobe, mem.keycode, mem.key_armed);
        else passed++;
        @(negedge clk);
        checks++;
        if (mem.keypress_strobe !== 1'b0)
            $display("FAIL key_strobe_width got %b expected 0", mem.keypress_strobe);
        else passed++;
        access(16'hC000, 8'hC1, 1'b1);
        checks++;
        if (mem.keypress_strobe !== 1'b0)
            $display("FAIL key_unarmed strobe got %b expected 0", mem.keypress_strobe);
        else passed++;
        access(16'hC010, 8'h00, 1'b1);
        access(16'hC000, 8'hC2, 1'b1);
        checks++;
        if ({mem.keypress_strobe, mem.keycode} !== {1'b1, 8'hC2})
            $display("FAIL key_rearm strobe/code got %b/%h expected 1/c2",
                     mem.keypress_strobe, mem.keycode);
        else passed++;
    endtask

`ifdef IIGS_SWITCHES_EN
    task automatic test_iigs();
        access(16'hC022, 8'hF6, 1'b0);
        access(16'hC034, 8'h05, 1'b0);
        access(16'hC029, 8'hA0, 1'b0);
        checks++;
        if ({mem.text_color, mem.background_color, mem.border_color, mem.shrg_mode,
             mem.monochrome_dhires_mode, mem.linearize_mode} !== {4'hF, 4'h6, 4'h5, 3'b110})
            $display("FAIL iigs_regs got %h/%h/%h/%b%b%b expected f/6/5/110",
                     mem.text_color, mem.background_color, mem.border_color,
                     mem.shrg_mode, mem.monochrome_dhires_mode, mem.linearize_mode);
        else passed++;
        access(16'h5000, 8'h00, 1'b0);
        checks++;
        if (mem.aux_mem !== 1'b1) $display("FAIL iigs_shadow aux got %b expected 1", mem.aux_mem);
        else passed++;
        access(16'hC029, 8'h00, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_pipeline();
        @(negedge clk);
        addr = 16'hC00F; data = 8'h00; rw_n = 1'b0; strobe = 1'b1;
        @(negedge clk);
        addr = 16'hC053; rst = 1'b1;
        @(negedge clk);
        strobe = 1'b0; rst = 1'b0;
        model_reset();
        checks++;
        if (dut_snap() !== RST_SNAP)
            $display("FAIL reset_mid_pipe got %h expected %h", dut_snap(), RST_SNAP);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_snap() !== RST_SNAP)
            $display("FAIL reset_discard got %h expected %h", dut_snap(), RST_SNAP);
        else passed++;
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] iigs [4] = '{16'hC021, 16'hC022, 16'hC029, 16'hC034};
        case ($urandom_range(0, 7))
            0: return 16'hC000 + 16'($urandom_range(0, 15));
            1: return 16'hC050 + 16'($urandom_range(0, 15));
            2: return {4'hC, 4'($urandom_range(1, 7)), 8'($urandom)};
            3: return 16'hCFFF;
            4: return 16'hC010;
            5: return 16'($urandom_range(0, 16'hBFFF));
            6: return iigs[$urandom_range(0, 3)];
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back();
        snap_t q[$];
        snap_t exp;
        for (int burst = 0; burst < 4; burst++) begin
            for (int k = 0; k < 18; k++) begin
                @(negedge clk);
                if (k >= 2) begin
                    exp = q.pop_front();
                    checks++;
                    if (dut_snap() !== exp)
                        $display("FAIL back_to_back[%0d.%0d] got %h expected %h",
                                 burst, k - 2, dut_snap(), exp);
                    else passed++;
                end
                if (k < 16) begin
                    addr = pick_addr(); data = 8'($urandom); rw_n = 1'($urandom);
                    strobe = 1'b1;
                    model_apply(addr, data, rw_n);
                    q.push_back(model_snap());
                end else begin
                    strobe = 1'b0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_switch_write();
        test_read_only();
        test_bus_enable();
        test_aux_mem();
        test_slot_rom();
        test_keyboard();
`ifdef IIGS_SWITCHES_EN
        test_iigs();
`endif
        test_back_to_back();
        test_reset_mid_pipeline();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
